uart_frame_loader: RTL

// - Parametrised host-command loader between uart_controller's RX byte stream and the imem banks, blockmem and thread-run control.
// - Decodes framed commands (PING, IMEM word, BMEM tile, UPDATE) and writes N per-thread imem banks plus a blockmem tile.
// - Adds an XOR checksum per frame, an inter-byte timeout and ACK/NACK response bytes back towards the UART TX path.

---
 rtl/loader_pkg.sv | 22 ++
 rtl/loader_resp_slot.sv | 53 +++++
 rtl/uart_frame_loader.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared opcodes, response codes and FSM state encoding for the UART frame loader.
package loader_pkg;

    localparam logic [1:0] OP_PING   = 2'b00;
    localparam logic [1:0] OP_IMEM   = 2'b01;
    localparam logic [1:0] OP_BMEM   = 2'b10;
    localparam logic [1:0] OP_UPDATE = 2'b11;

    localparam logic [7:0] RESP_PING    = 8'h55;
    localparam logic [7:0] RESP_ACK     = 8'hAC;
    localparam logic [7:0] RESP_TIMEOUT = 8'hE0;
    localparam logic [7:0] RESP_CSUM    = 8'hE1;
    localparam logic [7:0] RESP_NOBANK  = 8'hE2;

    typedef enum logic [1:0] {
        S_CMD  = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_CSUM = 2'd3
    } state_e;

endpackage

// File: rtl/loader_resp_slot.sv
// One-entry response holding register towards the UART TX path.
// Accept and load may coincide; a load into a full, non-accepted slot is dropped.
module loader_resp_slot (
    input  logic       clock,
    input  logic       reset,
    input  logic       load_i,
    input  logic [7:0] load_data_i,
    input  logic       ready_i,
    output logic       valid_o,
    output logic [7:0] data_o,
    output logic       overrun_o
);

    logic       valid_q, valid_d;
    logic [7:0] data_q, data_d;
    logic       overrun_q, overrun_d;
    logic       accept;

    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        overrun_d = overrun_q;
        accept    = valid_q & ready_i;
        if (accept) begin
            valid_d = 1'b0;
        end
        if (load_i) begin
            if (!valid_q || accept) begin
                valid_d = 1'b1;
                data_d  = load_data_i;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/uart_frame_loader.sv
// Host command loader: turns the UART RX byte stream into imem bank writes,
// blockmem tile writes and thread-run updates, answering each command with a response byte.
//
//   state  | meaning
//   S_CMD  | idle, waiting for a command byte
//   S_ADDR | collecting BYTES little-endian address bytes
//   S_DATA | collecting the imem word or the blockmem tile
//   S_CSUM | waiting for the XOR checksum byte
module uart_frame_loader
    import loader_pkg::*;
#(
    parameter int BITWIDTH       = 32,
    parameter int NUM_THREADS    = 3,
    parameter int BMEM_WORDS     = 16,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [7:0]                     rx_data,
    input  logic                           rx_valid,
    output logic [7:0]                     resp_data,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic                           resp_overrun,
    output logic [BITWIDTH-1:0]            write_addr,
    output logic [BITWIDTH-1:0]            imem_write_data,
    output logic [NUM_THREADS-1:0]         imem_write_valid,
    output logic [BMEM_WORDS*BITWIDTH-1:0] bmem_write_data,
    output logic                           bmem_write_valid,
    output logic [NUM_THREADS-1:0]         thread_running,
    output logic                           busy
);

    localparam int BYTES      = BITWIDTH / 8;
    localparam int TILE_BYTES = BYTES * BMEM_WORDS;
    localparam int TILE_W     = BMEM_WORDS * BITWIDTH;
    localparam int CW         = $clog2(TILE_BYTES + 1);
    localparam int TW         = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [CW-1:0] ADDR_LAST = CW'(BYTES - 1);
    localparam logic [CW-1:0] WORD_LAST = CW'(BYTES - 1);
    localparam logic [CW-1:0] TILE_LAST = CW'(TILE_BYTES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [7:0]               csum_q, csum_d;
    logic [TW-1:0]            idle_q, idle_d;
    logic                     is_bmem_q, is_bmem_d;
    logic [NUM_THREADS-1:0]   run_q, run_d;
    logic [NUM_THREADS-1:0]   imem_wv_q, imem_wv_d;
    logic                     bmem_wv_q, bmem_wv_d;
    logic [BITWIDTH-1:0]      addr_q;
    logic [BITWIDTH-1:0]      imem_data_q;
    logic [TILE_W-1:0]        tile_q;

    logic                     addr_shift;
    logic                     word_shift;
    logic                     tile_shift;
    logic                     resp_load;
    logic [7:0]               resp_code;
    logic                     timed_out;
    logic [NUM_THREADS-1:0]   free_oh;
    logic                     free_found;

    // Lowest-index bank whose thread is not running; later iterations win.
    always_comb begin
        free_oh    = '0;
        free_found = 1'b0;
        for (int t = NUM_THREADS - 1; t >= 0; t--) begin
            if (!run_q[t]) begin
                free_oh    = '0;
                free_oh[t] = 1'b1;
                free_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        csum_d     = csum_q;
        idle_d     = idle_q;
        is_bmem_d  = is_bmem_q;
        run_d      = run_q;
        imem_wv_d  = '0;
        bmem_wv_d  = 1'b0;
        addr_shift = 1'b0;
        word_shift = 1'b0;
        tile_shift = 1'b0;
        resp_load  = 1'b0;
        resp_code  = RESP_ACK;
        timed_out  = 1'b0;

        if (state_q == S_CMD || rx_valid) begin
            idle_d = '0;
        end else if (idle_q != TO_MAX) begin
            idle_d = idle_q + TW'(1);
        end

        if (TIMEOUT_CYCLES > 0 && state_q != S_CMD && !rx_valid && idle_q == TO_LAST) begin
            timed_out = 1'b1;
        end

        case (state_q)
            S_CMD: begin
                if (rx_valid) begin
                    case (rx_data[7:6])
                        OP_PING: begin
                            resp_load = 1'b1;
                            resp_code = RESP_PING;
                        end
                        OP_UPDATE: begin
                            run_d     = rx_data[NUM_THREADS-1:0];
                            resp_load = 1'b1;
                            resp_code = RESP_ACK;
                        end
                        default: begin
                            is_bmem_d = (rx_data[7:6] == OP_BMEM);
                            csum_d    = '0;
                            cnt_d     = '0;
                            state_d   = S_ADDR;
                        end
                    endcase
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    addr_shift = 1'b1;
                    csum_d     = csum_q ^ rx_data;
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    tile_shift = is_bmem_q;
                    word_shift = !is_bmem_q;
                    csum_d     = csum_q ^ rx_data;
                    if (cnt_q == (is_bmem_q ? TILE_LAST : WORD_LAST)) begin
                        cnt_d   = '0;
                        state_d = S_CSUM;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_CSUM: begin
                if (rx_valid) begin
                    cnt_d     = '0;
                    state_d   = S_CMD;
                    resp_load = 1'b1;
                    if (rx_data != csum_q) begin
                        resp_code = RESP_CSUM;
                    end else if (is_bmem_q) begin
                        bmem_wv_d = 1'b1;
                        resp_code = RESP_ACK;
                    end else if (free_found) begin
                        imem_wv_d = free_oh;
                        resp_code = RESP_ACK;
                    end else begin
                        resp_code = RESP_NOBANK;
                    end
                end
            end
            default: begin
                state_d = S_CMD;
            end
        endcase

        // Timeout only fires on cycles without rx_valid, so it never collides with a byte response.
        if (timed_out) begin
            state_d   = S_CMD;
            cnt_d     = '0;
            resp_load = 1'b1;
            resp_code = RESP_TIMEOUT;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_CMD;
            cnt_q       <= '0;
            csum_q      <= '0;
            idle_q      <= '0;
            is_bmem_q   <= 1'b0;
            run_q       <= '0;
            imem_wv_q   <= '0;
            bmem_wv_q   <= 1'b0;
            addr_q      <= '0;
            imem_data_q <= '0;
            tile_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            csum_q    <= csum_d;
            idle_q    <= idle_d;
            is_bmem_q <= is_bmem_d;
            run_q     <= run_d;
            imem_wv_q <= imem_wv_d;
            bmem_wv_q <= bmem_wv_d;
            // Little-endian fields shift in from the top so byte k ends at bit 8*k.
            if (addr_shift) begin
                addr_q <= (addr_q >> 8) | (BITWIDTH'(rx_data) << (BITWIDTH - 8));
            end
            if (word_shift) begin
                imem_data_q <= (imem_data_q >> 8) | (BITWIDTH'(rx_data) << (BITWIDTH - 8));
            end
            if (tile_shift) begin
                tile_q <= (tile_q >> 8) | (TILE_W'(rx_data) << (TILE_W - 8));
            end
        end
    end

    loader_resp_slot u_resp_slot (
        .clock       (clock),
        .reset       (reset),
        .load_i      (resp_load),
        .load_data_i (resp_code),
        .ready_i     (resp_ready),
        .valid_o     (resp_valid),
        .data_o      (resp_data),
        .overrun_o   (resp_overrun)
    );

    assign write_addr       = addr_q;
    assign imem_write_data  = imem_data_q;
    assign imem_write_valid = imem_wv_q;
    assign bmem_write_data  = tile_q;
    assign bmem_write_valid = bmem_wv_q;
    assign thread_running   = run_q;
    assign busy             = (state_q != S_CMD);

endmodule
